// File: rtl/fpu_addsub.sv
// -----------------------------------------------------------------------------
// fpu_addsub
//   IEEE-754 floating-point adder/subtractor behind the FPU ready/ack operand
//   handshake. Subnormal operands are flushed to signed zero. Rounding is
//   round-to-nearest-even. The datapath is iterative: one FSM step per cycle,
//   and normalisation shifts left by one bit per cycle.
//
// Parameters
//   bitness     total float width: 16, 32 or 64
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   input_rdy   producer has valid operands and operation
//   input_ack   one-cycle pulse: operands captured
//   data_a      operand A
//   data_b      operand B
//   operation   4'b0000 add, 4'b0001 sub (A-B), anything else is invalid
//   output_rdy  result valid, held until acknowledged
//   output_ack  consumer takes the result
//   result      packed IEEE result
//   flags       {invalid, overflow, underflow, inexact}, valid with output_rdy
// -----------------------------------------------------------------------------
module fpu_addsub #(
  parameter int bitness = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               input_rdy,
  output logic               input_ack,
  input  logic [bitness-1:0] data_a,
  input  logic [bitness-1:0] data_b,
  input  logic [3:0]         operation,
  output logic               output_rdy,
  input  logic               output_ack,
  output logic [bitness-1:0] result,
  output logic [3:0]         flags
);

  localparam int E = (bitness == 16) ? 5 : (bitness == 64) ? 11 : 8;
  localparam int M = bitness - E - 1;
  // Internal mantissa: {carry, hidden, M fraction bits, guard, round, sticky}.
  localparam int W = M + 5;

  localparam logic [3:0]   op_add  = 4'b0000;
  localparam logic [3:0]   op_sub  = 4'b0001;
  localparam logic [E-1:0] exp_max = '1;
  // One wider than the field so overflow past all-ones is still visible.
  localparam logic [E:0]   exp_inf = {1'b0, exp_max};
  localparam logic [E:0]   exp_one = 1;

  localparam logic [bitness-1:0] canonical_nan =
    {1'b0, exp_max, 1'b1, {(M-1){1'b0}}};

  typedef enum logic [2:0] {
    get_input,
    unpack,
    special,
    align,
    add,
    normalize,
    round,
    put_result
  } state_t;

  state_t state;

  // Captured operands.
  logic [bitness-1:0] a_q, b_q;
  logic [3:0]         op_q;

  // Unpacked fields (B's sign already reflects the operation).
  logic         sign_a, sign_b;
  logic [E-1:0] exp_a, exp_b;
  logic [M-1:0] frac_a, frac_b;

  // Aligned operands: big has the larger exponent, small is shifted.
  logic         big_sign_q, small_sign_q;
  logic [W-1:0] big_man_q, small_man_q;

  // Working value carried through normalize / round / pack.
  logic         w_sign;
  logic [E:0]   w_exp;
  logic [W-1:0] w_man;

  // Results decided before pack (specials, exact zero, flush) bypass pack.
  logic               direct;
  logic [bitness-1:0] direct_res;
  logic [3:0]         pend_flags;

  // Operand classification from the unpacked fields.
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, bad_op;

  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == exp_max) && (frac_a == '0);
  assign inf_b  = (exp_b == exp_max) && (frac_b == '0);
  assign nan_a  = (exp_a == exp_max) && (frac_a != '0);
  assign nan_b  = (exp_b == exp_max) && (frac_b != '0);
  assign bad_op = (op_q != op_add) && (op_q != op_sub);

  // Right shift that folds every bit shifted out into the sticky position.
  function automatic logic [W-1:0] shr_sticky(input logic [W-1:0] m,
                                              input logic [E-1:0] d);
    logic [W-1:0] lost;
    lost = m & ~({W{1'b1}} << d);
    if (int'(d) > M + 3) return W'(1);
    return (m >> d) | W'(lost != '0);
  endfunction

  // Operand ordering for align: the larger exponent stays put.
  logic         big_sign, small_sign;
  logic [E-1:0] big_exp, exp_diff;
  logic [M-1:0] big_frac, small_frac;
  logic [W-1:0] small_shifted;

  always_comb begin
    // NOTE: every output gets a default before the if, so no path can leave
    // one unassigned and infer a latch.
    big_sign   = sign_a;
    big_exp    = exp_a;
    big_frac   = frac_a;
    small_sign = sign_b;
    small_frac = frac_b;
    exp_diff   = exp_a - exp_b;
    if (exp_b > exp_a) begin
      big_sign   = sign_b;
      big_exp    = exp_b;
      big_frac   = frac_b;
      small_sign = sign_a;
      small_frac = frac_a;
      exp_diff   = exp_b - exp_a;
    end
    small_shifted = shr_sticky({2'b01, small_frac, 3'b000}, exp_diff);
  end

  // Round-to-nearest-even on the normalised working mantissa.
  logic         g_bit, r_bit, s_bit, round_inc;
  logic [M+1:0] rounded;

  assign g_bit     = w_man[2];
  assign r_bit     = w_man[1];
  assign s_bit     = w_man[0];
  assign round_inc = g_bit & (r_bit | s_bit | w_man[3]);
  assign rounded   = w_man[W-1:3] + (M+2)'(round_inc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= get_input;
      input_ack    <= 1'b0;
      output_rdy   <= 1'b0;
      result       <= '0;
      flags        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      exp_a        <= '0;
      exp_b        <= '0;
      frac_a       <= '0;
      frac_b       <= '0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      big_man_q    <= '0;
      small_man_q  <= '0;
      w_sign       <= 1'b0;
      w_exp        <= '0;
      w_man        <= '0;
      direct       <= 1'b0;
      direct_res   <= '0;
      pend_flags   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register samples
      // the pre-edge values, independent of statement order.
      input_ack <= 1'b0;

      unique case (state)
        get_input: begin
          if (input_rdy) begin
            a_q       <= data_a;
            b_q       <= data_b;
            op_q      <= operation;
            input_ack <= 1'b1;
            state     <= unpack;
          end
        end

        unpack: begin
          sign_a     <= a_q[bitness-1];
          sign_b     <= b_q[bitness-1] ^ (op_q == op_sub);
          exp_a      <= a_q[bitness-2 -: E];
          exp_b      <= b_q[bitness-2 -: E];
          frac_a     <= a_q[M-1:0];
          frac_b     <= b_q[M-1:0];
          direct     <= 1'b0;
          pend_flags <= '0;
          state      <= special;
        end

        special: begin
          direct <= 1'b1;
          state  <= put_result;
          if (bad_op || nan_a || nan_b) begin
            direct_res <= canonical_nan;
            pend_flags <= {bad_op, 3'b000};
          end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            direct_res <= canonical_nan;
            pend_flags <= 4'b1000;
          end else if (inf_a) begin
            direct_res <= {sign_a, exp_max, {M{1'b0}}};
          end else if (inf_b) begin
            direct_res <= {sign_b, exp_max, {M{1'b0}}};
          end else if (zero_a && zero_b) begin
            direct_res <= {sign_a & sign_b, {(bitness-1){1'b0}}};
          end else if (zero_a) begin
            direct_res <= {sign_b, exp_b, frac_b};
          end else if (zero_b) begin
            direct_res <= {sign_a, exp_a, frac_a};
          end else begin
            direct <= 1'b0;
            state  <= align;
          end
        end

        align: begin
          big_sign_q   <= big_sign;
          small_sign_q <= small_sign;
          big_man_q    <= {2'b01, big_frac, 3'b000};
          small_man_q  <= small_shifted;
          w_exp        <= {1'b0, big_exp};
          state        <= add;
        end

        add: begin
          state <= normalize;
          if (big_sign_q == small_sign_q) begin
            w_man  <= big_man_q + small_man_q;
            w_sign <= big_sign_q;
          end else if (big_man_q > small_man_q) begin
            w_man  <= big_man_q - small_man_q;
            w_sign <= big_sign_q;
          end else if (small_man_q > big_man_q) begin
            w_man  <= small_man_q - big_man_q;
            w_sign <= small_sign_q;
          end else begin
            direct     <= 1'b1;
            direct_res <= '0;
            state      <= put_result;
          end
        end

        normalize: begin
          if (w_man[W-1]) begin
            // Carry out of the add: hidden bit is guaranteed set afterwards.
            w_man <= {1'b0, w_man[W-1:2], w_man[1] | w_man[0]};
            w_exp <= w_exp + exp_one;
            state <= round;
          end else if (!w_man[W-2]) begin
            if (w_exp > exp_one) begin
              w_man <= w_man << 1;
              w_exp <= w_exp - exp_one;
            end else begin
              // Would need a subnormal result: flush to signed zero.
              direct     <= 1'b1;
              direct_res <= {w_sign, {(bitness-1){1'b0}}};
              pend_flags <= 4'b0011;
              state      <= put_result;
            end
          end else begin
            state <= round;
          end
        end

        round: begin
          pend_flags <= {3'b000, g_bit | r_bit | s_bit};
          if (rounded[M+1]) begin
            w_man <= {1'b0, rounded[M+1:1], 3'b000};
            w_exp <= w_exp + exp_one;
          end else begin
            w_man <= {rounded, 3'b000};
          end
          state <= put_result;
        end

        put_result: begin
          if (!output_rdy) begin
            // Entry cycle: pack and present the result.
            output_rdy <= 1'b1;
            if (direct) begin
              result <= direct_res;
              flags  <= pend_flags;
            end else if (w_exp >= exp_inf) begin
              result <= {w_sign, exp_max, {M{1'b0}}};
              flags  <= pend_flags | 4'b0101;
            end else begin
              result <= {w_sign, w_exp[E-1:0], w_man[M+2:3]};
              flags  <= pend_flags;
            end
          end else if (output_ack) begin
            output_rdy <= 1'b0;
            state      <= get_input;
          end
        end

        default: state <= get_input;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// -----------------------------------------------------------------------------
// tb_fpu_addsub
//   Directed bench for fpu_addsub at bitness 16, 32 and 64. All instances
//   share clock and reset; only the selected instance sees input_rdy and
//   output_ack, and its outputs are muxed onto common observation signals.
//   Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fpu_addsub;

  localparam logic [3:0] op_add = 4'b0000;
  localparam logic [3:0] op_sub = 4'b0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_rdy = 1'b0;
  logic        out_ack = 1'b0;
  logic [63:0] drv_a = '0;
  logic [63:0] drv_b = '0;
  logic [3:0]  drv_op = '0;
  int          sel_w = 32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic        ack16, rdy16, ack32, rdy32, ack64, rdy64;
  logic [15:0] res16;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [3:0]  fl16, fl32, fl64;

  fpu_addsub #(.bitness(16)) dut16 (
    .clock(clock), .reset(reset),
    .input_rdy(in_rdy && sel_w == 16), .input_ack(ack16),
    .data_a(drv_a[15:0]), .data_b(drv_b[15:0]), .operation(drv_op),
    .output_rdy(rdy16), .output_ack(out_ack && sel_w == 16),
    .result(res16), .flags(fl16)
  );

  fpu_addsub #(.bitness(32)) dut32 (
    .clock(clock), .reset(reset),
    .input_rdy(in_rdy && sel_w == 32), .input_ack(ack32),
    .data_a(drv_a[31:0]), .data_b(drv_b[31:0]), .operation(drv_op),
    .output_rdy(rdy32), .output_ack(out_ack && sel_w == 32),
    .result(res32), .flags(fl32)
  );

  fpu_addsub #(.bitness(64)) dut64 (
    .clock(clock), .reset(reset),
    .input_rdy(in_rdy && sel_w == 64), .input_ack(ack64),
    .data_a(drv_a), .data_b(drv_b), .operation(drv_op),
    .output_rdy(rdy64), .output_ack(out_ack && sel_w == 64),
    .result(res64), .flags(fl64)
  );

  logic        ack_m, rdy_m;
  logic [63:0] res_m;
  logic [3:0]  fl_m;

  always_comb begin
    ack_m = ack32;
    rdy_m = rdy32;
    res_m = 64'(res32);
    fl_m  = fl32;
    if (sel_w == 16) begin
      ack_m = ack16;
      rdy_m = rdy16;
      res_m = 64'(res16);
      fl_m  = fl16;
    end else if (sel_w == 64) begin
      ack_m = ack64;
      rdy_m = rdy64;
      res_m = res64;
      fl_m  = fl64;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait (bounded) for input_ack, confirm it is one cycle.
  task automatic start_op(input string tag, input int w, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] op);
    logic seen;
    @(negedge clock);
    sel_w  = w;
    drv_a  = a;
    drv_b  = b;
    drv_op = op;
    in_rdy = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = ack_m;
    end
    ack_cyc = cyc;
    in_rdy  = 1'b0;
    check({tag, "/input_ack_seen"}, 64'(seen), 64'd1);
    @(negedge clock);
    check({tag, "/input_ack_pulse"}, 64'(ack_m), 64'd0);
  endtask

  // Wait (bounded) for output_rdy, check result/flags/latency, optionally
  // hold output_ack low for a while, then acknowledge.
  task automatic finish_op(input string tag, input logic [63:0] exp_res,
                           input int exp_fl, input int exp_lat, input int hold);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      seen = rdy_m;
      if (!seen) @(negedge clock);
    end
    check({tag, "/output_rdy_seen"}, 64'(seen), 64'd1);
    check({tag, "/result"}, res_m, exp_res);
    if (exp_fl >= 0) check({tag, "/flags"}, 64'(fl_m), 64'(exp_fl));
    if (exp_lat >= 0) check({tag, "/latency"}, 64'(cyc - ack_cyc), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "/hold_rdy"}, 64'(rdy_m), 64'd1);
      check({tag, "/hold_result"}, res_m, exp_res);
    end
    out_ack = 1'b1;
    @(negedge clock);
    out_ack = 1'b0;
    check({tag, "/rdy_drop"}, 64'(rdy_m), 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clock);
    check("reset/input_ack", 64'(ack32), 64'd0);
    check("reset/output_rdy", 64'(rdy32), 64'd0);
    check("reset/result", 64'(res32), 64'd0);
    check("reset/flags", 64'(fl32), 64'd0);
    reset = 1'b0;

    // 1 + 1 = 2, carry path, held result while output_ack stays low.
    start_op("add_1_1", 32, 64'h3F800000, 64'h3F800000, op_add);
    finish_op("add_1_1", 64'h40000000, 4'b0000, 7, 10);

    // 1 - 1 = +0 exactly.
    start_op("sub_1_1", 32, 64'h3F800000, 64'h3F800000, op_sub);
    finish_op("sub_1_1", 64'h00000000, 4'b0000, -1, 0);

    // 1 + 2^-24: exact tie, rounds down to even.
    start_op("tie_even", 32, 64'h3F800000, 64'h33800000, op_add);
    finish_op("tie_even", 64'h3F800000, 4'b0001, -1, 0);

    // 1 + (2^-24 + ulp): above the tie, rounds up.
    start_op("above_tie", 32, 64'h3F800000, 64'h33800001, op_add);
    finish_op("above_tie", 64'h3F800001, 4'b0001, -1, 0);

    // max + max overflows to +inf.
    start_op("overflow", 32, 64'h7F7FFFFF, 64'h7F7FFFFF, op_add);
    finish_op("overflow", 64'h7F800000, 4'b0101, -1, 0);

    // inf - inf is invalid, special path latency.
    start_op("inf_m_inf", 32, 64'h7F800000, 64'h7F800000, op_sub);
    finish_op("inf_m_inf", 64'h7FC00000, 4'b1000, 3, 0);

    // NaN operand gives canonical NaN.
    start_op("nan_in", 32, 64'h7FC00001, 64'h3F800000, op_add);
    finish_op("nan_in", 64'h7FC00000, -1, 3, 0);

    // Full cancellation: 23 left-shift normalise steps.
    start_op("cancel", 32, 64'h3F800001, 64'h3F800000, op_sub);
    finish_op("cancel", 64'h34000000, 4'b0000, 30, 0);

    // Invalid operation code.
    start_op("bad_op", 32, 64'h3F800000, 64'h3F800000, 4'b0010);
    finish_op("bad_op", 64'h7FC00000, 4'b1000, 3, 0);

    // Half and double precision.
    start_op("h_add_1_1", 16, 64'h3C00, 64'h3C00, op_add);
    finish_op("h_add_1_1", 64'h4000, 4'b0000, 7, 0);
    start_op("d_add_1_1", 64, 64'h3FF0000000000000, 64'h3FF0000000000000, op_add);
    finish_op("d_add_1_1", 64'h4000000000000000, 4'b0000, 7, 0);

    // Reset while a cancellation is normalising: outputs clear at once.
    start_op("rst_mid", 32, 64'h3F800001, 64'h3F800000, op_sub);
    repeat (5) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("rst_mid/input_ack", 64'(ack32), 64'd0);
    check("rst_mid/output_rdy", 64'(rdy32), 64'd0);
    check("rst_mid/result", 64'(res32), 64'd0);
    check("rst_mid/flags", 64'(fl32), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rdy32) check("rst_mid/abandoned", 64'(rdy32), 64'd0);
    end
    check("rst_mid/no_result", 64'(rdy32), 64'd0);

    start_op("post_rst", 32, 64'h3F800000, 64'h3F800000, op_add);
    finish_op("post_rst", 64'h40000000, 4'b0000, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_addsub.md
Name: fpu_addsub

Overview:
- Parametrised IEEE-754 floating-point adder/subtractor. Successor to the current single-width add path.
- Adds operation select (add/sub), correct special-case handling, iterative normalisation, round-to-nearest-even and status flags.
- Sits behind the same ready/ack operand handshake as the rest of the FPU, so it can be used directly as the FPU add/sub datapath.

Parameters:
- bitness, 32, total float width; legal values 16, 32, 64. E = 5/8/11 exponent bits, M = 10/23/52 mantissa bits, bias = 2^(E-1)-1.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- input_rdy  in  1  producer has valid operands and operation
- input_ack  out  1  one-cycle pulse: operands captured
- data_a  in  bitness  operand A
- data_b  in  bitness  operand B
- operation  in  4 (Word_t)  4'b0000 add, 4'b0001 sub (A-B), others invalid
- output_rdy  out  1  result valid, held until acknowledged
- output_ack  in  1  consumer takes result
- result  out  bitness  packed IEEE result
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with output_rdy

Behaviour:
- Reset (async, active-high) forces state get_input and sets input_ack=0, output_rdy=0, result=0, flags=0. Reset mid-operation abandons the operation; no result is produced.
- get_input: if input_rdy, capture data_a, data_b and operation; input_ack=1 for exactly one cycle; go to unpack. Inputs are ignored in every other state.
- unpack: split sign/exp/mantissa. Exp=0 means zero; subnormal inputs are flushed to signed zero. Sub inverts B's sign.
- special (one cycle), in priority order:
  - invalid operation code, or either operand NaN -> canonical NaN (sign 0, exp all ones, mantissa MSB 1, rest 0).
  - inf - inf (effective) -> canonical NaN, invalid=1.
  - any inf -> that inf.
  - both zero -> -0 only if both signs negative, else +0.
  - one zero -> the other operand unchanged.
  - All of the above go to put_result. Otherwise go to align.
- Internal mantissa is M+5 bits: carry, hidden, M, guard, round, sticky.
- align (one cycle): shift the smaller-exponent mantissa right by the exponent difference; OR every bit shifted out into sticky. If the difference exceeds M+3, the mantissa becomes sticky=1 only. Result exp = larger exp.
- add (one cycle):
  - equal effective signs: add mantissas.
  - otherwise: subtract the smaller magnitude from the larger; result sign = sign of the larger magnitude.
  - exact zero difference -> +0, go to put_result.
- normalize: one action per cycle.
  - carry set: shift right 1 (sticky ORed), exp+1.
  - else, while hidden=0 and exp>1: shift left 1, exp-1.
  - hidden=0 at exp=1 -> result flushes to signed zero, underflow=1, inexact=1.
  - Bounded at M+3 cycles.
- round (one cycle), round-to-nearest-even:
  - increment if G & (R|S|LSB).
  - inexact = G|R|S.
  - mantissa overflow from the increment -> shift right 1, exp+1.
- pack: exp >= 2^E-1 -> signed inf, overflow=1, inexact=1. Otherwise assemble {sign, exp, mantissa[M-1:0]}.
- put_result:
  - result and flags are registered and stable while output_rdy=1.
  - output_rdy rises the cycle after entry.
  - When output_rdy & output_ack are sampled high: output_rdy=0 next cycle and return to get_input.
  - output_ack while output_rdy=0 is ignored.
- Latency from the input_ack cycle to output_rdy high:
  - specials: 3 cycles.
  - normal path: 7 cycles + number of left-shift normalise steps; maximum 7+M+3.
- Back-to-back: the next input_ack occurs at the earliest 1 cycle after the acknowledged result.

Test Plan:
- bitness=32: add 0x3F800000 + 0x3F800000 -> result 0x40000000, flags 0000. input_ack is a single pulse; output_rdy is held with output_ack low for 10 cycles, and result stays constant throughout.
- Sub 0x3F800000 - 0x3F800000 -> 0x00000000, flags 0000. Add 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 with inexact=1. Add 0x3F800000 + 0x33800001 -> 0x3F800001 with inexact=1.
- Add 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1. Sub 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1. Add 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Cancellation: sub 0x3F800001 - 0x3F800000 -> 0x34000000 after 23 normalise steps; check the latency counter reads 30. Operation 4'b0010 -> 0x7FC00000, invalid=1.
- bitness=16: add 0x3C00 + 0x3C00 -> 0x4000. bitness=64: add 0x3FF0000000000000 + 0x3FF0000000000000 -> 0x4000000000000000.
- Assert reset in the normalize state of a cancellation op -> output_rdy, input_ack, result and flags all 0 immediately (asynchronously, before the next clock edge). The next operation, add 0x3F800000 + 0x3F800000, completes normally with result 0x40000000.
